exh_stim_misr: RTL and testbench
================================

Name: exh_stim_misr

Overview:
- Self-checking harness stage placed around a combinational regression netlist: it enumerates every primary-input vector, receives the netlist outputs, and compacts them into a MISR signature compared against a golden value.
- Upstream of the netlist, it drives the pi bus.
- Downstream of the netlist, it consumes the po bus.
- Used to regression-check re-synthesised netlists against the original.

Parameters:
- N_IN, 6, primary-input width; vectors 0..2^N_IN-1 issued in ascending order.
- N_OUT, 5, primary-output width; must be <= MISR_W.
- MISR_W, 16, signature width.
- POLY, 16'h1021, MISR feedback polynomial.
- SEED, 16'h0000, signature value on start.
- GOLDEN, 16'h0000, expected final signature.
- TIMEOUT, 16, maximum idle cycles allowed in DRAIN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- stim_o  out  N_IN  current vector, driven to pi bus.
- stim_valid  out  1  stim_o is valid.
- stim_ready  in  1  netlist side accepts stim_o.
- resp_i  in  N_OUT  po bus.
- resp_valid  in  1  resp_i is valid.
- done  out  1  run finished.
- pass  out  1  done & signature==GOLDEN & !err.
- err  out  1  timeout or unsolicited response.
- signature  out  MISR_W  current MISR value.
- vec_count  out  N_IN+1  vectors accepted so far.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: rst_n low forces the following immediately, regardless of clk, including mid-run:
  - state IDLE
  - stim_o=0, stim_valid=0
  - done=0, pass=0, err=0
  - signature=0, vec_count=0
  - internal resp_cnt=0, timeout counter=0
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - stim_valid=0.
  - start=1 -> on the edge: signature<=SEED, vec_count<=0, resp_cnt<=0, err<=0; go RUN.
- RUN:
  - stim_valid=1, stim_o=vec_count[N_IN-1:0].
  - Stimulus handshake = stim_valid & stim_ready; each one increments vec_count.
  - stim_o holds while stim_ready=0.
  - Handshake with vec_count==2^N_IN-1 -> DRAIN; vec_count becomes 2^N_IN.
  - start is ignored.
- Response handshake (RUN or DRAIN only):
  - When resp_valid=1: signature <= {signature[MISR_W-2:0],1'b0} ^ (signature[MISR_W-1] ? POLY : 0) ^ zero-extended resp_i; resp_cnt++.
  - Stimulus and response handshakes may occur in the same cycle. This is the normal case for a combinational netlist with resp_valid tied to stim_valid&stim_ready.
  - A response counts as unsolicited when resp_cnt already equals the accepted-stimulus count, including the stimulus accepted that cycle. An unsolicited response sets err sticky, does not update signature, and does not increment resp_cnt.
- DRAIN:
  - stim_valid=0.
  - resp_cnt==2^N_IN (registered) -> DONE.
  - Otherwise the timeout counter increments each cycle without a response and resets on a response.
  - Counter reaching TIMEOUT -> err<=1, go DONE.
- DONE:
  - done=1; pass=(signature==GOLDEN)&!err; signature frozen.
  - resp_valid is ignored.
  - start=1 -> restart exactly as from IDLE; done and pass drop on that edge.
- Latency: with stim_ready=1 throughout, the start edge is E0; vectors are accepted at edges E1..E64; DONE is entered at E65 (N_IN=6).
- Reaching DONE from RUN directly is not permitted; DRAIN is always at least one cycle.

Test Plan:
- Zero response: resp_i=0, resp_valid=stim_valid&stim_ready, stim_ready=1, start pulse -> stim_o counts 0..63 on consecutive cycles; done at E65; signature=16'h0000; pass=1; err=0; vec_count=64.
- Single-hot response: resp_i=5'h01 only for vector 63, else 0 -> signature=16'h0001, pass=0 (GOLDEN=0). The same with vector 62 only -> signature=16'h0002.
- Backpressure: stim_ready alternating 1,0 -> each stim_o value held for 2 cycles; 64 vectors accepted; DONE entered 128 cycles after start plus 1; the signature matches the stim_ready=1 run.
- Reset mid-run: rst_n low after vector 20 is accepted -> all outputs 0 immediately. Restart yields the same signature and timing as a clean run.
- Missing responses: suppress resp_valid for vector 63 -> DRAIN holds 16 cycles; then done=1, err=1, pass=0, signature equal to the 63-response value.
- Unsolicited response: resp_valid=1 in RUN with stim_ready=0 and all stimuli answered -> err=1, signature unchanged. resp_valid in DONE is ignored. A start in DONE clears err and reruns.

Source files
------------

// File: rtl/exh_stim_misr.sv
// rtl/exh_stim_misr.sv - exhaustive stimulus generator with MISR response compaction
module exh_stim_misr #(
    parameter int unsigned N_IN    = 6,
    parameter int unsigned N_OUT   = 5,
    parameter int unsigned MISR_W  = 16,
    parameter logic [MISR_W-1:0] POLY   = 16'h1021,
    parameter logic [MISR_W-1:0] SEED   = 16'h0000,
    parameter logic [MISR_W-1:0] GOLDEN = 16'h0000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   stim_o,
    output logic              stim_valid,
    input  logic              stim_ready,
    input  logic [N_OUT-1:0]  resp_i,
    input  logic              resp_valid,
    output logic              done,
    output logic              pass,
    output logic              err,
    output logic [MISR_W-1:0] signature,
    output logic [N_IN:0]     vec_count
);

    localparam int unsigned CW = N_IN + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_VEC = CW'((1 << N_IN) - 1);
    localparam logic [CW-1:0] ALL_VEC  = CW'(1 << N_IN);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_o_q, stim_o_d;
    logic              stim_valid_q, stim_valid_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_q, err_d;
    logic [MISR_W-1:0] sig_q, sig_d;
    logic [CW-1:0]     vec_q, vec_d;
    logic [CW-1:0]     resp_cnt_q, resp_cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              stim_hs;
    logic              resp_active;
    logic [CW-1:0]     accepted;
    logic              resp_ok;
    logic              resp_unsol;
    logic [MISR_W-1:0] misr_next;

    // Next-state and next-output computation for the whole harness
    always_comb begin
        state_d      = state_q;
        stim_o_d     = stim_o_q;
        stim_valid_d = stim_valid_q;
        err_d        = err_q;
        sig_d        = sig_q;
        vec_d        = vec_q;
        resp_cnt_d   = resp_cnt_q;
        tmo_d        = tmo_q;

        // stim_valid is only ever high in RUN, so this is the RUN handshake
        stim_hs     = stim_valid_q & stim_ready;
        resp_active = (state_q == S_RUN) || (state_q == S_DRAIN);
        // a response is only owed for stimuli accepted up to and including this cycle
        accepted    = vec_q + CW'(stim_hs);
        resp_ok     = resp_active && resp_valid && (resp_cnt_q != accepted);
        resp_unsol  = resp_active && resp_valid && (resp_cnt_q == accepted);
        misr_next   = {sig_q[MISR_W-2:0], 1'b0}
                    ^ (sig_q[MISR_W-1] ? POLY : '0)
                    ^ MISR_W'(resp_i);

        if (resp_ok) begin
            sig_d      = misr_next;
            resp_cnt_d = resp_cnt_q + CW'(1);
        end
        if (resp_unsol) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    sig_d        = SEED;
                    vec_d        = '0;
                    resp_cnt_d   = '0;
                    tmo_d        = '0;
                    err_d        = 1'b0;
                    stim_o_d     = '0;
                    stim_valid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (stim_hs) begin
                    vec_d    = vec_q + CW'(1);
                    stim_o_d = vec_d[N_IN-1:0];
                    if (vec_q == LAST_VEC) begin
                        state_d      = S_DRAIN;
                        stim_valid_d = 1'b0;
                        tmo_d        = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (resp_cnt_q == ALL_VEC) begin
                    state_d = S_DONE;
                end else if (resp_ok) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TMO_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // done/pass are registered, so they are derived from the next-state values
        done_d = (state_d == S_DONE);
        pass_d = done_d && (sig_d == GOLDEN) && !err_d;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            stim_o_q     <= '0;
            stim_valid_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 1'b0;
            sig_q        <= '0;
            vec_q        <= '0;
            resp_cnt_q   <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            stim_o_q     <= stim_o_d;
            stim_valid_q <= stim_valid_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            sig_q        <= sig_d;
            vec_q        <= vec_d;
            resp_cnt_q   <= resp_cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign stim_o     = stim_o_q;
    assign stim_valid = stim_valid_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err        = err_q;
    assign signature  = sig_q;
    assign vec_count  = vec_q;

endmodule

// File: tb/tb_exh_stim_misr.sv
// tb/tb_exh_stim_misr.sv - randomized self-checking bench for exh_stim_misr
module tb_exh_stim_misr;

    localparam int BUDGET = 400;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  stim_o;
    logic        stim_valid;
    logic        stim_ready;
    logic [4:0]  resp_i;
    logic        resp_valid;
    logic        done;
    logic        pass;
    logic        err;
    logic [15:0] signature;
    logic [6:0]  vec_count;

    logic [4:0]  tbl [64];
    bit          rdy [512];
    bit          drop63;
    bit          inject_now;

    int n_vec;
    int n_err;

    exh_stim_misr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stim_o     (stim_o),
        .stim_valid (stim_valid),
        .stim_ready (stim_ready),
        .resp_i     (resp_i),
        .resp_valid (resp_valid),
        .done       (done),
        .pass       (pass),
        .err        (err),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational netlist stand-in: table lookup, response valid with the handshake
    always_comb begin
        resp_valid = inject_now |
                     (stim_valid & stim_ready & !(drop63 && stim_o == 6'd63));
        resp_i     = inject_now ? 5'h1f : tbl[stim_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference signature: fold of the delivered responses in vector order
    function automatic logic [15:0] ref_sig(input bit skip63);
        int s = 0;
        for (int v = 0; v < 64; v++) begin
            if (!(skip63 && v == 63)) begin
                s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 0) ^ int'(tbl[v]);
            end
        end
        return s[15:0];
    endfunction

    // edge at which the 64th vector is accepted, given the ready pattern
    function automatic int last_acc_edge();
        int n = 0;
        for (int j = 1; j < 512; j++) begin
            if (rdy[j]) n++;
            if (n == 64) return j;
        end
        return -1;
    endfunction

    task automatic set_rdy(input int mode);
        for (int j = 0; j < 512; j++) begin
            case (mode)
                0:       rdy[j] = 1'b1;
                1:       rdy[j] = (j % 2 == 0);
                default: rdy[j] = (j >= 200) || ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic set_tbl(input int mode, input int hot);
        for (int v = 0; v < 64; v++) begin
            case (mode)
                0:       tbl[v] = 5'h00;
                1:       tbl[v] = (v == hot) ? 5'h01 : 5'h00;
                default: tbl[v] = 5'($urandom);
            endcase
        end
    endtask

    // one complete run from IDLE/DONE; call at #1 after a posedge
    task automatic run_test(input string name, input bit inject);
        int          edge_n;
        int          acc;
        int          done_edge;
        int          exp_last;
        int          exp_done;
        logic [15:0] exp_sig;
        bit          exp_err;

        if (inject) rdy[1] = 1'b0;
        exp_last = last_acc_edge();
        exp_done = drop63 ? exp_last + 16 : exp_last + 1;
        exp_sig  = ref_sig(drop63);
        exp_err  = drop63 || inject;

        start = 1'b1;
        stim_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, ":start_done"}, {31'd0, done}, 32'd0);
        check({name, ":start_err"}, {31'd0, err}, 32'd0);

        edge_n = 0;
        acc = 0;
        done_edge = -1;
        while (edge_n < BUDGET && done_edge < 0) begin
            stim_ready = rdy[edge_n + 1];
            inject_now = inject && (edge_n == 0);
            @(negedge clk);
            if (edge_n + 1 <= exp_last) begin
                check({name, ":stim_valid"}, {31'd0, stim_valid}, 32'd1);
                check({name, ":stim_o"}, {26'd0, stim_o}, acc);
                if (rdy[edge_n + 1]) acc++;
            end
            @(posedge clk); #1;
            inject_now = 1'b0;
            edge_n++;
            if (inject && edge_n == 1) begin
                check({name, ":unsol_err"}, {31'd0, err}, 32'd1);
                check({name, ":unsol_sig"}, {16'd0, signature}, 32'h0000);
            end
            if (done) done_edge = edge_n;
        end
        stim_ready = 1'b0;

        check({name, ":done_edge"}, done_edge, exp_done);
        check({name, ":signature"}, {16'd0, signature}, {16'd0, exp_sig});
        check({name, ":err"}, {31'd0, err}, {31'd0, exp_err});
        check({name, ":pass"}, {31'd0, pass}, {31'd0, (exp_sig == 16'h0000) && !exp_err});
        check({name, ":vec_count"}, {25'd0, vec_count}, 32'd64);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stim_ready = 1'b0;
        drop63 = 1'b0;
        inject_now = 1'b0;
        set_tbl(0, 0);
        set_rdy(0);

        @(posedge clk); #1;
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:pass", {31'd0, pass}, 32'd0);
        check("rst:err", {31'd0, err}, 32'd0);
        check("rst:stim_valid", {31'd0, stim_valid}, 32'd0);
        check("rst:stim_o", {26'd0, stim_o}, 32'd0);
        check("rst:signature", {16'd0, signature}, 32'd0);
        check("rst:vec_count", {25'd0, vec_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // all-zero responses
        set_tbl(0, 0);
        set_rdy(0);
        run_test("zero", 1'b0);
        check("zero:pass_const", {31'd0, pass}, 32'd1);

        // single-hot responses
        set_tbl(1, 63);
        run_test("hot63", 1'b0);
        check("hot63:sig_const", {16'd0, signature}, 32'h0001);
        set_tbl(1, 62);
        run_test("hot62", 1'b0);
        check("hot62:sig_const", {16'd0, signature}, 32'h0002);

        // random responses under full, alternating and random backpressure
        set_tbl(2, 0);
        set_rdy(0);
        run_test("rnd_full", 1'b0);
        set_rdy(1);
        run_test("rnd_alt", 1'b0);
        set_rdy(2);
        run_test("rnd_bp", 1'b0);

        // reset mid-run after vector 20 is accepted
        set_rdy(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stim_ready = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst:stim_valid", {31'd0, stim_valid}, 32'd0);
        check("midrst:stim_o", {26'd0, stim_o}, 32'd0);
        check("midrst:signature", {16'd0, signature}, 32'd0);
        check("midrst:vec_count", {25'd0, vec_count}, 32'd0);
        check("midrst:done", {31'd0, done}, 32'd0);
        stim_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_test("after_rst", 1'b0);

        // missing response for vector 63
        drop63 = 1'b1;
        set_tbl(2, 0);
        run_test("drop63", 1'b0);
        drop63 = 1'b0;

        // unsolicited response in RUN, then responses in DONE are ignored
        set_tbl(2, 0);
        set_rdy(2);
        run_test("unsol", 1'b1);
        begin
            logic [15:0] held;
            held = ref_sig(1'b0);
            inject_now = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            inject_now = 1'b0;
            check("done_resp:signature", {16'd0, signature}, {16'd0, held});
            check("done_resp:done", {31'd0, done}, 32'd1);
            check("done_resp:err", {31'd0, err}, 32'd1);
        end

        // restart from DONE clears err
        set_rdy(0);
        run_test("restart", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
